// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the byte-sequenced 16x16 multiplier.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTE_W = 8;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  // Each selected high byte contributes a factor of 2^8 to the partial product.
  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [1:0] n_hi;
    n_hi = {1'b0, step[0]} + {1'b0, step[1]};
    return {n_hi, 3'b000};
  endfunction

endpackage

// File: rtl/EightBitArrayMultiplier.sv
// Combinational 8x8 unsigned array multiplier core.
// Latency: 0 cycles (purely combinational).
// Backpressure: none, output follows inputs every cycle.
module EightBitArrayMultiplier
  import mul_seq_pkg::*;
(
  input  logic [BYTE_W-1:0]   a,
  input  logic [BYTE_W-1:0]   b,
  output logic [2*BYTE_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p + ({{BYTE_W{1'b0}}, a} << i);
    end
  end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiply sequenced over four byte-pair products on one 8x8 core.
// Latency: out_valid 5 cycles after acceptance (6 with REG_PP=1).
// Backpressure: result held until out_ready; no new operands accepted until then.
module mul16_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned REG_PP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              busy
);

  state_t                state;
  logic [OP_W-1:0]       a_q;
  logic [OP_W-1:0]       b_q;
  logic [1:0]            step;
  logic [BYTE_W-1:0]     a_byte;
  logic [BYTE_W-1:0]     b_byte;
  logic [2*BYTE_W-1:0]   core_p;
  logic [2*BYTE_W-1:0]   pp_q;
  logic [1:0]            pp_step;
  logic                  pp_vld;
  logic [PROD_W-1:0]     acc;
  logic [2*BYTE_W-1:0]   add_src;
  logic [4:0]            add_shift;
  logic                  add_en;
  logic [PROD_W-1:0]     addend;

  assign in_ready = (state == IDLE) && !clr;
  assign busy     = (state != IDLE);
  assign out_p    = acc;

  assign a_byte = step[0] ? a_q[OP_W-1:BYTE_W] : a_q[BYTE_W-1:0];
  assign b_byte = step[1] ? b_q[OP_W-1:BYTE_W] : b_q[BYTE_W-1:0];

  EightBitArrayMultiplier u_core (
    .a (a_byte),
    .b (b_byte),
    .p (core_p)
  );

  // With REG_PP the accumulator trails the core by one cycle, using the step
  // that was registered alongside the partial product.
  always_comb begin
    add_src   = core_p;
    add_shift = step_shift(step);
    add_en    = (state == MUL);
    if (REG_PP != 0) begin
      add_src   = pp_q;
      add_shift = step_shift(pp_step);
      add_en    = pp_vld;
    end
    addend = PROD_W'(add_src) << add_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      step      <= '0;
      pp_q      <= '0;
      pp_step   <= '0;
      pp_vld    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      step      <= '0;
      pp_vld    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      pp_q    <= core_p;
      pp_step <= step;
      pp_vld  <= (state == MUL);
      if (add_en) acc <= acc + addend;

      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state     <= (REG_PP != 0) ? DRAIN : DONE;
            out_valid <= (REG_PP == 0);
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Directed bench for mul16_seq_ctrl with REG_PP=0 and REG_PP=1 instances.
module tb_mul16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        clr0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [15:0] in_a0, in_b0;
  logic [31:0] out_p0;

  logic        clr1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [15:0] in_a1, in_b1;
  logic [31:0] out_p1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul16_seq_ctrl #(.REG_PP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0), .busy(busy0)
  );

  mul16_seq_ctrl #(.REG_PP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_p(out_p1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic ov(input bit s);
    return s ? out_valid1 : out_valid0;
  endfunction
  function automatic logic ir(input bit s);
    return s ? in_ready1 : in_ready0;
  endfunction
  function automatic logic [31:0] op(input bit s);
    return s ? out_p1 : out_p0;
  endfunction

  task automatic drv(input bit s, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (s) begin in_valid1 = v; in_a1 = a; in_b1 = b; end
    else   begin in_valid0 = v; in_a0 = a; in_b0 = b; end
  endtask

  task automatic set_ordy(input bit s, input logic r);
    if (s) out_ready1 = r; else out_ready0 = r;
  endtask

  // Entered and left at posedge+#1; issues one operation and completes the handshake.
  task automatic run_mul(input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
    int   lat;
    logic rdy_low;
    drv(s, 1'b1, a, b);
    chk({name, "_in_ready"}, 32'(ir(s)), 32'd1);
    @(posedge clk); #1;
    drv(s, 1'b0, ~a, ~b);
    lat = 1;
    rdy_low = 1'b1;
    while (!ov(s) && lat < 20) begin
      if (ir(s)) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ir(s)) rdy_low = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_out_p"}, op(s), exp);
    chk({name, "_rdy_low"}, 32'(rdy_low), 32'd1);
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    set_ordy(s, 1'b0);
    chk({name, "_ov_clear"}, 32'(ov(s)), 32'd0);
    chk({name, "_rdy_back"}, 32'(ir(s)), 32'd1);
  endtask

  initial begin
    int   lat;
    logic stable, rdy_low, seen;
    logic [31:0] held;

    vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[3] = '{16'h00FF, 16'h0100, 32'h0000FF00};
    vecs[4] = '{16'h0100, 16'h0100, 32'h00010000};
    vecs[5] = '{16'hFF00, 16'h00FF, 32'h00FE0100};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};

    rst_n = 1'b0;
    clr0 = 0; in_valid0 = 0; in_a0 = 0; in_b0 = 0; out_ready0 = 0;
    clr1 = 0; in_valid1 = 0; in_a1 = 0; in_b1 = 0; out_ready1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_out_p", out_p0, 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_mul(1'b0, vecs[i].a, vecs[i].b, vecs[i].p, 5, $sformatf("vec%0d", i));

    // Output stall with a second operand pair already waiting.
    drv(1'b0, 1'b1, 16'h1234, 16'h5678);
    @(posedge clk); #1;
    drv(1'b0, 1'b1, 16'hFF00, 16'h00FF);
    lat = 1;
    while (!out_valid0 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 32'(lat), 32'd5);
    held = out_p0;
    stable = 1'b1;
    rdy_low = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (out_p0 !== held || !out_valid0) stable = 1'b0;
      if (in_ready0) rdy_low = 1'b0;
    end
    chk("bp_out_p", held, 32'h06260060);
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_rdy_low", 32'(rdy_low), 32'd1);
    chk("bp_busy", 32'(busy0), 32'd1);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    chk("bp_ov_clear", 32'(out_valid0), 32'd0);
    run_mul(1'b0, 16'hFF00, 16'h00FF, 32'h00FE0100, 5, "bp_second");

    // clr while idle must block acceptance.
    clr0 = 1'b1;
    drv(1'b0, 1'b1, 16'h0003, 16'h0003);
    #1;
    chk("clr_idle_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    chk("clr_idle_busy", 32'(busy0), 32'd0);
    clr0 = 1'b0;
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);

    // clr during step 2 aborts the operation.
    drv(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) begin @(posedge clk); #1; end
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("clr_busy", 32'(busy0), 32'd0);
    chk("clr_out_p", out_p0, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid0) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("clr_no_out_valid", 32'(seen), 32'd0);
    run_mul(1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 5, "after_clr");

    // Asynchronous reset during step 1.
    drv(1'b0, 1'b1, 16'hABCD, 16'h1234);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_out_valid", 32'(out_valid0), 32'd0);
    chk("arst_out_p", out_p0, 32'd0);
    chk("arst_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(1'b0, 16'h1234, 16'h5678, 32'h06260060, 5, "after_arst");

    // Registered partial-product variant.
    run_mul(1'b1, 16'h8001, 16'h0003, 32'h00018003, 6, "regpp_a");
    run_mul(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 6, "regpp_b");
    run_mul(1'b1, 16'hFF00, 16'h00FF, 32'h00FE0100, 6, "regpp_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
